result_writer: RTL and testbench

Output-side counterpart to the linear-regression data loader. It captures the per-sample error values produced by the error-computation stage into an internal register file. Once the configured sample count has been captured, it streams them back out in index order over a valid/ready handshake toward the result sink. A single-cycle `done` pulse marks completion so the top-level controller can end the run.

---
 rtl/result_writer.sv | 127 ++++++++++++
 tb/tb_result_writer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/result_writer.sv
`default_nettype none
// ============================================================================
//  Module   : result_writer
//  Captures per-sample error values into a register file, then streams them
//  back out in index order over a valid/ready handshake with a done pulse.
//  Revision : 1.0
// ============================================================================
module result_writer #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 150,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_samples,
    input  logic              err_valid,
    input  logic [DATA_W-1:0] err_in,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_count,
    output logic              done
);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_COLLECT = 2'd1;
    localparam logic [1:0]       c_DRAIN   = 2'd2;
    localparam logic [1:0]       c_DONE    = 2'd3;
    localparam logic [CNT_W-1:0] c_DEPTH   = CNT_W'(DEPTH);

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  n_eff_q,     n_eff_d;
    logic [CNT_W-1:0]  wr_count_q,  wr_count_d;
    logic [CNT_W-1:0]  out_index_q, out_index_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0]  w_n_eff;
    logic [CNT_W-1:0]  w_wr_next;
    logic              w_mem_we;

    // The clamp keeps every counter strictly below 2^CNT_W.
    assign w_n_eff   = (n_samples > c_DEPTH) ? c_DEPTH : n_samples;
    assign w_wr_next = wr_count_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= c_IDLE;
            n_eff_q     <= '0;
            wr_count_q  <= '0;
            out_index_q <= '0;
        end else begin
            state_q     <= state_d;
            n_eff_q     <= n_eff_d;
            wr_count_q  <= wr_count_d;
            out_index_q <= out_index_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_eff_d     = n_eff_q;
        wr_count_d  = wr_count_q;
        out_index_d = out_index_q;
        w_mem_we    = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    n_eff_d     = w_n_eff;
                    wr_count_d  = '0;
                    out_index_d = '0;
                    state_d     = (w_n_eff == '0) ? c_DONE : c_COLLECT;
                end
            end
            c_COLLECT: begin
                if (err_valid) begin
                    w_mem_we   = 1'b1;
                    wr_count_d = w_wr_next;
                    if (w_wr_next == n_eff_q) begin
                        state_d = c_DRAIN;
                    end
                end
            end
            c_DRAIN: begin
                if (out_ready) begin
                    out_index_d = out_index_q + 1'b1;
                    if (out_index_q == n_eff_q - 1'b1) begin
                        state_d = c_DONE;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[wr_count_q] <= err_in;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        data_out  = '0;
        case (state_q)
            c_COLLECT: busy = 1'b1;
            c_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                data_out  = mem_q[out_index_q];
            end
            c_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign out_index = out_index_q;
    assign wr_count  = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_result_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_writer
//  Directed and randomized runs checked against a queue-based sample model.
//  Revision : 1.0
// ============================================================================
module tb_result_writer;

    localparam int DATA_W = 20;
    localparam int DEPTH  = 150;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  n_samples;
    logic              err_valid;
    logic [DATA_W-1:0] err_in;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  out_index;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic [CNT_W-1:0]  wr_count;
    logic              done;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] fixed_pat [4];

    always #5 clk = ~clk;

    result_writer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_samples (n_samples),
        .err_valid (err_valid),
        .err_in    (err_in),
        .data_out  (data_out),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .wr_count  (wr_count),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_data_out"},  32'(data_out),  32'd0);
        chk({tag, "_out_index"}, 32'(out_index), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_wr_count"},  32'(wr_count),  32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    // vmode: 0 every cycle, 1 alternating, 2 random.  rmode: 0 always ready,
    // 1 three-cycle stall after the first handshake, 2 random.
    task automatic run(input int n, input int vmode, input int rmode,
                       input bit noise, input bit fixed);
        logic [DATA_W-1:0] model [$];
        int neff, cnt, idx, cyc, guard;
        bit ev, rdy;
        neff = (n > DEPTH) ? DEPTH : n;
        model.delete();
        n_samples = CNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_samples = CNT_W'($urandom);
        if (neff == 0) begin
            chk("zero_done",      32'(done),      32'd1);
            chk("zero_busy",      32'(busy),      32'd0);
            chk("zero_out_valid", 32'(out_valid), 32'd0);
            return;
        end
        chk("start_busy",     32'(busy),      32'd1);
        chk("start_wr_count", 32'(wr_count),  32'd0);
        chk("start_out_valid",32'(out_valid), 32'd0);
        cnt = 0; cyc = 0; guard = 0;
        while (cnt < neff && guard < 4000) begin
            case (vmode)
                0:       ev = 1'b1;
                1:       ev = (cyc % 2 == 0);
                default: ev = ($urandom_range(3) != 0);
            endcase
            err_valid = ev;
            err_in = (fixed && cnt < 4) ? fixed_pat[cnt[1:0]] : DATA_W'($urandom);
            start = noise & ($urandom_range(1) == 1);
            tick();
            if (ev) begin
                model.push_back(err_in);
                cnt++;
            end
            chk("collect_wr_count", 32'(wr_count), 32'(cnt));
            cyc++; guard++;
        end
        if (cnt < neff) chk("collect_timeout", 32'd0, 32'd1);
        err_valid = 1'b0;
        start = 1'b0;
        idx = 0; cyc = 0; guard = 0;
        while (idx < neff && guard < 4000) begin
            chk("drain_out_valid", 32'(out_valid), 32'd1);
            chk("drain_out_index", 32'(out_index), 32'(idx));
            chk("drain_data_out",  32'(data_out),  32'(model[idx]));
            chk("drain_done",      32'(done),      32'd0);
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = !(cyc >= 1 && cyc <= 3);
                default: rdy = ($urandom_range(2) != 0);
            endcase
            out_ready = rdy;
            if (noise) begin
                err_valid = ($urandom_range(1) == 1);
                err_in = 20'h12345;
                start = ($urandom_range(1) == 1);
            end
            tick();
            if (rdy) idx++;
            cyc++; guard++;
        end
        if (idx < neff) chk("drain_timeout", 32'd0, 32'd1);
        out_ready = ($urandom_range(1) == 1);
        err_valid = 1'b0;
        start = 1'b0;
        chk("end_done",      32'(done),      32'd1);
        chk("end_out_valid", 32'(out_valid), 32'd0);
        chk("end_busy",      32'(busy),      32'd0);
        chk("end_wr_count",  32'(wr_count),  32'(neff));
        tick();
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        fixed_pat[0] = 20'h00001;
        fixed_pat[1] = 20'hFFFFF;
        fixed_pat[2] = 20'h7FFFF;
        fixed_pat[3] = 20'h80000;
        rst = 1'b0;
        start = 1'b0;
        n_samples = '0;
        err_valid = 1'b0;
        err_in = '0;
        out_ready = 1'b0;
        tick();
        chk_idle_outputs("reset");
        tick();
        rst = 1'b1;
        tick();
        chk_idle_outputs("after_reset");

        run(4, 0, 0, 1'b0, 1'b1);
        run(3, 1, 1, 1'b0, 1'b0);
        run(200, 2, 2, 1'b0, 1'b0);
        run(150, 0, 0, 1'b0, 1'b0);
        run(1, 2, 2, 1'b1, 1'b0);

        // Zero-length run, then a start held through the done cycle.
        run(0, 0, 0, 1'b0, 1'b0);
        n_samples = '0;
        start = 1'b1;
        tick();
        chk("b2b_idle_done", 32'(done), 32'd0);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        chk("b2b_done",      32'(done),      32'd1);
        chk("b2b_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("b2b_post_done", 32'(done), 32'd0);

        run(6, 2, 2, 1'b1, 1'b0);
        repeat (3) run(int'($urandom_range(20, 1)), 2, 2, 1'b1, 1'b0);

        // Abort after two of five captures.
        n_samples = CNT_W'(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        err_valid = 1'b1;
        err_in = DATA_W'($urandom);
        tick();
        err_in = DATA_W'($urandom);
        tick();
        err_valid = 1'b0;
        chk("pre_abort_wr_count", 32'(wr_count), 32'd2);
        #2 rst = 1'b0;
        #1 chk_idle_outputs("abort");
        repeat (3) begin
            tick();
            chk("abort_hold_done", 32'(done), 32'd0);
        end
        rst = 1'b1;
        tick();
        chk("abort_release_busy", 32'(busy), 32'd0);
        chk("abort_release_done", 32'(done), 32'd0);
        run(2, 0, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
